axi_req_arbiter: RTL and testbench

Slave-NI request-side arbiter that sits between the AXI AW/AR address channels and the request packetizer. It picks one transaction, write or read, at a time and presents it as the packetizer's single address channel with a one-hot `active_select`. It holds that choice until the packetizer pulses `release_trans`. Write/read priority alternates round-robin on every release, and an optional watchdog flags transactions the packetizer never releases.

---
 rtl/axi_req_arbiter.sv | 112 +++++++++++
 tb/tb_axi_req_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_req_arbiter.sv
// axi_req_arbiter: picks one AW or AR transaction at a time for the request packetizer, round-robin on release.
// Optional stuck-transaction watchdog is built when REQ_ARB_WATCHDOG_EN is defined.
module axi_req_arbiter #(
    parameter int unsigned ADDR_CHAN_W = 41,
    parameter int unsigned WDOG_LIMIT  = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_CHAN_W-1:0] aw_chan,
    input  logic                   aw_valid,
    output logic                   aw_ready,
    input  logic [ADDR_CHAN_W-1:0] ar_chan,
    input  logic                   ar_valid,
    output logic                   ar_ready,
    output logic [ADDR_CHAN_W-1:0] addr_chan,
    input  logic                   addr_ready,
    output logic [1:0]             active_select,
    input  logic [1:0]             release_trans,
    output logic                   busy,
    output logic                   arb_timeout
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   prio;
    logic   prio_nxt;
    logic   released;

    if (WDOG_LIMIT < 2) begin : g_limit_check
        $error("WDOG_LIMIT must be at least 2");
    end

    // The released type is never re-granted in its release cycle: only the other type may follow directly.
    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        released  = 1'b0;
        unique case (state)
            IDLE: begin
                if (aw_valid && (!ar_valid || !prio)) begin
                    state_nxt = WRITE;
                end else if (ar_valid) begin
                    state_nxt = READ;
                end
            end
            WRITE: begin
                if (release_trans[0]) begin
                    released  = 1'b1;
                    prio_nxt  = 1'b1;
                    state_nxt = ar_valid ? READ : IDLE;
                end
            end
            READ: begin
                if (release_trans[1]) begin
                    released  = 1'b1;
                    prio_nxt  = 1'b0;
                    state_nxt = aw_valid ? WRITE : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            prio          <= 1'b0;
            active_select <= '0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            prio          <= prio_nxt;
            active_select <= {state_nxt == READ, state_nxt == WRITE};
            busy          <= (state_nxt != IDLE);
        end
    end

    assign aw_ready  = (state == WRITE) && addr_ready;
    assign ar_ready  = (state == READ) && addr_ready;
    assign addr_chan = (state == READ) ? ar_chan : aw_chan;

`ifdef REQ_ARB_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT);

    logic [WDOG_W-1:0] wdog_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wdog_cnt    <= '0;
            arb_timeout <= 1'b0;
        end else begin
            if (wdog_cnt == WDOG_MAX) begin
                arb_timeout <= 1'b1;
            end
            if (state == IDLE || released) begin
                wdog_cnt <= '0;
            end else if (wdog_cnt != WDOG_MAX) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
        end
    end
`else
    assign arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Scoreboard bench for axi_req_arbiter: a cycle model queues expected outputs, a negedge monitor compares.
module tb_axi_req_arbiter;
    localparam int unsigned AW  = 41;
    localparam int unsigned LIM = 4;
`ifdef REQ_ARB_WATCHDOG_EN
    localparam logic EXP_TO = 1'b1;
`else
    localparam logic EXP_TO = 1'b0;
`endif

    logic          clk = 1'b1;
    logic          rst;
    logic [AW-1:0] aw_chan;
    logic          aw_valid;
    logic          aw_ready;
    logic [AW-1:0] ar_chan;
    logic          ar_valid;
    logic          ar_ready;
    logic [AW-1:0] addr_chan;
    logic          addr_ready;
    logic [1:0]    active_select;
    logic [1:0]    release_trans;
    logic          busy;
    logic          arb_timeout;

    axi_req_arbiter #(.ADDR_CHAN_W(AW), .WDOG_LIMIT(LIM)) dut (
        .clk           (clk),
        .rst           (rst),
        .aw_chan       (aw_chan),
        .aw_valid      (aw_valid),
        .aw_ready      (aw_ready),
        .ar_chan       (ar_chan),
        .ar_valid      (ar_valid),
        .ar_ready      (ar_ready),
        .addr_chan     (addr_chan),
        .addr_ready    (addr_ready),
        .active_select (active_select),
        .release_trans (release_trans),
        .busy          (busy),
        .arb_timeout   (arb_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            en;
        logic [1:0]    sel;
        logic          busy;
        logic          awr;
        logic          arr;
        logic [AW-1:0] addr;
        logic          prio;
        logic          to;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: 0 idle, 1 write, 2 read
    int          m_state = 0;
    bit          m_prio  = 1'b0;
    bit          m_to    = 1'b0;
    bit          m_known = 1'b0;
    int unsigned m_cnt   = 0;

    logic [1:0]  obs_sel;
    logic        obs_busy;
    logic        obs_prio;
    logic        obs_to;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.en) begin
                check("active_select", 64'(active_select), 64'(e.sel));
                check("busy", 64'(busy), 64'(e.busy));
                check("aw_ready", 64'(aw_ready), 64'(e.awr));
                check("ar_ready", 64'(ar_ready), 64'(e.arr));
                check("prio", 64'(dut.prio), 64'(e.prio));
                check("arb_timeout", 64'(arb_timeout), 64'(e.to));
                if (e.busy) check("addr_chan", 64'(addr_chan), 64'(e.addr));
            end
        end
    end

    task automatic model_step();
        int  ns;
        bit  rel;
        if (!rst) begin
            m_state = 0;
            m_prio  = 1'b0;
            m_to    = 1'b0;
            m_cnt   = 0;
            m_known = 1'b1;
        end else begin
            rel = (m_state == 1 && release_trans[0]) || (m_state == 2 && release_trans[1]);
`ifdef REQ_ARB_WATCHDOG_EN
            if (m_cnt == LIM) m_to = 1'b1;
            if (m_state != 0 && !rel) m_cnt = (m_cnt < LIM) ? m_cnt + 1 : m_cnt;
            else m_cnt = 0;
`endif
            ns = m_state;
            if (m_state == 0) begin
                if (aw_valid && ar_valid) ns = m_prio ? 2 : 1;
                else if (aw_valid) ns = 1;
                else if (ar_valid) ns = 2;
            end else if (m_state == 1 && rel) begin
                m_prio = 1'b1;
                ns = ar_valid ? 2 : 0;
            end else if (m_state == 2 && rel) begin
                m_prio = 1'b0;
                ns = aw_valid ? 1 : 0;
            end
            m_state = ns;
        end
    endtask

    task automatic tick();
        exp_t e;
        e.en   = m_known;
        e.sel  = (m_state == 1) ? 2'b01 : (m_state == 2) ? 2'b10 : 2'b00;
        e.busy = (m_state != 0);
        e.awr  = (m_state == 1) && addr_ready;
        e.arr  = (m_state == 2) && addr_ready;
        e.addr = (m_state == 2) ? ar_chan : aw_chan;
        e.prio = m_prio;
        e.to   = m_to;
        sb.push_back(e);
        @(negedge clk);
        obs_sel  = active_select;
        obs_busy = busy;
        obs_prio = dut.prio;
        obs_to   = arb_timeout;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic aw_v, input logic ar_v, input logic rdy, input logic [1:0] rel);
        logic [63:0] r;
        aw_valid      = aw_v;
        ar_valid      = ar_v;
        addr_ready    = rdy;
        release_trans = rel;
        r = {$urandom, $urandom};
        aw_chan = r[AW-1:0];
        r = {$urandom, $urandom};
        ar_chan = r[AW-1:0];
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, errors %0d", errors);
        $fatal(1, "time limit");
    end

    initial begin
        int grants;
        int wg;
        int rg;
        int gaps;
        int rels;
        logic [1:0] prev_sel;
        logic [1:0] rel;
        bit p0;

        rst = 1'b0;
        drive(0, 0, 0, 2'b00);
        drive(0, 0, 0, 2'b00);
        check("reset_sel", 64'(obs_sel), 64'd0);
        check("reset_busy", 64'(obs_busy), 64'd0);
        rst = 1'b1;

        // simultaneous request after reset: write wins, read follows the write release
        drive(1, 1, 0, 2'b00);
        drive(0, 1, 0, 2'b00);
        check("t1_grant_write", 64'(obs_sel), 64'h1);
        drive(0, 1, 0, 2'b00);
        drive(0, 1, 1, 2'b00);
        drive(0, 1, 0, 2'b00);
        drive(0, 1, 0, 2'b01);
        drive(0, 0, 1, 2'b10);
        check("t1_grant_read", 64'(obs_sel), 64'h2);
        drive(0, 0, 0, 2'b00);
        check("t1_prio_after_read", 64'(obs_prio), 64'd0);
        check("t1_idle", 64'(obs_sel), 64'd0);

        // read-only stream, released one cycle after each grant is seen
        grants   = 0;
        prev_sel = 2'b00;
        for (int i = 0; i < 12; i++) begin
            if (m_state == 2 && prev_sel == 2'b10) drive(0, 1, 1, 2'b10);
            else drive(0, 1, 0, 2'b00);
            if (obs_sel == 2'b10 && prev_sel != 2'b10) begin
                check("t2_grant_cycle", 64'(i), 64'(1 + 3 * grants));
                grants++;
            end
            prev_sel = obs_sel;
        end
        check("t2_grant_count", 64'(grants), 64'd4);
        for (int i = 0; i < 4 && m_state != 0; i++) drive(0, 0, 1, 2'b10);

        // fairness: both valid, release every granted cycle
        wg = 0; rg = 0; gaps = 0; rels = 0;
        for (int i = 0; i < 60 && rels < 20; i++) begin
            rel = (m_state == 1) ? 2'b01 : (m_state == 2) ? 2'b10 : 2'b00;
            if (rel != 2'b00) rels++;
            drive(1, 1, rel != 2'b00, rel);
            if (rel != 2'b00) begin
                if (obs_sel == 2'b01) wg++;
                else if (obs_sel == 2'b10) rg++;
            end else if (rels > 0) begin
                gaps++;
            end
        end
        check("t3_write_grants", 64'(wg), 64'd10);
        check("t3_read_grants", 64'(rg), 64'd10);
        check("t3_idle_gaps", 64'(gaps), 64'd0);
        for (int i = 0; i < 4 && m_state != 0; i++)
            drive(0, 0, 1, (m_state == 1) ? 2'b01 : 2'b10);

        // spurious and dual release while writing
        drive(1, 0, 0, 2'b00);
        p0 = m_prio;
        drive(0, 0, 0, 2'b10);
        check("t4_write_granted", 64'(obs_sel), 64'h1);
        drive(0, 0, 0, 2'b00);
        check("t4_still_write", 64'(obs_sel), 64'h1);
        check("t4_prio_kept", 64'(obs_prio), 64'(p0));
        drive(0, 0, 0, 2'b11);
        drive(0, 0, 0, 2'b00);
        check("t4_released", 64'(obs_sel), 64'd0);
        check("t4_prio_read_first", 64'(obs_prio), 64'd1);

        // reset while reading
        drive(0, 1, 0, 2'b00);
        rst = 1'b0;
        drive(0, 0, 0, 2'b00);
        check("t5_read_before_reset", 64'(obs_sel), 64'h2);
        rst = 1'b1;
        drive(0, 0, 0, 2'b00);
        check("t5_sel_after_reset", 64'(obs_sel), 64'd0);
        check("t5_busy_after_reset", 64'(obs_busy), 64'd0);
        check("t5_prio_after_reset", 64'(obs_prio), 64'd0);

        // watchdog: write granted at cycle 1, never released
        drive(1, 0, 0, 2'b00);
        for (int i = 1; i <= 8; i++) begin
            drive(0, 0, 0, 2'b00);
            if (i == 5) check("t6_no_timeout_yet", 64'(obs_to), 64'd0);
            if (i == 6) check("t6_timeout", 64'(obs_to), 64'(EXP_TO));
        end
        drive(0, 0, 0, 2'b01);
        drive(0, 0, 0, 2'b00);
        check("t6_timeout_sticky", 64'(obs_to), 64'(EXP_TO));

        // random traffic
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
